// File: rtl/bus_slave_port.sv
// bus_slave_port: device-side responder on the shared bus.
// It captures address and control when the controller acks this device.
// It then moves burst+1 words between the bus and a simple local memory port.
// During the data phase it paces the master through the WAIT bit in ctrl_out.
module bus_slave_port #(
   parameter int BUS_WIDTH  = 32,
   parameter int CTRL_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ack,
   input  logic [CTRL_WIDTH-1:0] ctrl_in,
   input  logic [BUS_WIDTH-1:0]  bus_in,
   output logic [CTRL_WIDTH-1:0] ctrl_out,
   output logic [BUS_WIDTH-1:0]  bus_out,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0]  mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [BUS_WIDTH-1:0]  mem_rdata,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_PRESENT,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_count;    // words still to move, 1..8 while active
   logic [2:0]            r_burst;
   logic                  r_we;
   logic [BUS_WIDTH-1:0]  r_bus_out;
   logic                  w_wait;

   // The controller's own WAIT bit and the reserved bits have no meaning for this port.
   logic w_unused_ctrl;
   assign w_unused_ctrl = ^{ctrl_in[CTRL_WIDTH-1:5], ctrl_in[0]};

   // State register plus the captured transaction context and read-data holding register
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (!reset) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_count   <= '0;
         r_burst   <= '0;
         r_we      <= 1'b0;
         r_bus_out <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (ack) begin
                  r_addr  <= bus_in[ADDR_WIDTH-1:0];
                  r_we    <= ctrl_in[1];
                  r_burst <= ctrl_in[4:2];
                  r_count <= {1'b0, ctrl_in[4:2]} + 4'd1;
               end
            end
            S_WRITE: begin
               if (mem_we) begin
                  r_addr  <= r_addr + ADDR_WIDTH'(1);
                  r_count <= r_count - 4'd1;
               end
            end
            S_RD_WAIT: begin
               if (ack && mem_rvalid) begin
                  r_bus_out <= mem_rdata;
               end
            end
            S_RD_PRESENT: begin
               if (ack) begin
                  r_addr  <= r_addr + ADDR_WIDTH'(1);
                  r_count <= r_count - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode plus the combinational memory strobes and the WAIT bit
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_next_state = r_state;
      w_wait       = 1'b1;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_wdata    = '0;
      case (r_state)
         S_IDLE: begin
            if (ack) begin
               w_next_state = ctrl_in[1] ? S_WRITE : S_RD_ISSUE;
            end
         end
         S_WRITE: begin
            w_wait = ~mem_ready;
            if (!ack) begin
               w_next_state = S_IDLE;
            end else if (mem_ready) begin
               mem_we    = 1'b1;
               mem_wdata = bus_in;
               if (r_count == 4'd1) begin
                  w_next_state = S_DONE;
               end
            end
         end
         S_RD_ISSUE: begin
            if (!ack) begin
               w_next_state = S_IDLE;
            end else if (mem_ready) begin
               mem_re       = 1'b1;
               w_next_state = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (!ack) begin
               w_next_state = S_IDLE;
            end else if (mem_rvalid) begin
               w_next_state = S_RD_PRESENT;
            end
         end
         S_RD_PRESENT: begin
            w_wait = 1'b0;
            if (!ack) begin
               w_next_state = S_IDLE;
            end else if (r_count == 4'd1) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_RD_ISSUE;
            end
         end
         S_DONE: begin
            if (!ack) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Control word back to the controller: {reserved zeros, burst, we, WAIT}
   always_comb begin
      ctrl_out      = '0;
      ctrl_out[0]   = w_wait;
      ctrl_out[1]   = r_we;
      ctrl_out[4:2] = r_burst;
   end

   assign mem_addr = r_addr;
   assign bus_out  = r_bus_out;
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_slave_port.sv
// Testbench for bus_slave_port: a per-cycle vector table plus a reset-mid-read sequence.
module tb_bus_slave_port;

   logic        clk;
   logic        reset;
   logic        ack;
   logic [7:0]  ctrl_in;
   logic [31:0] bus_in;
   logic [7:0]  ctrl_out;
   logic [31:0] bus_out;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   bus_slave_port #(.BUS_WIDTH(32), .CTRL_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .ack        (ack),
      .ctrl_in    (ctrl_in),
      .bus_in     (bus_in),
      .ctrl_out   (ctrl_out),
      .bus_out    (bus_out),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock cycle: inputs held for that cycle, outputs expected before its edge.
   typedef struct {
      logic        rst_n;
      logic        ack;
      logic [7:0]  ctrl;
      logic [31:0] bus;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic [7:0]  e_ctrl;
      logic [31:0] e_bus;
      logic [15:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_we;
      logic        e_re;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst_n, input logic a, input logic [7:0] c, input logic [31:0] b,
                      input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic [7:0] e_c, input logic [31:0] e_b, input logic [15:0] e_a,
                      input logic [31:0] e_wd, input logic e_we, input logic e_re, input logic e_busy);
      vec_t v;
      v.rst_n = rst_n; v.ack = a; v.ctrl = c; v.bus = b; v.rdy = rdy; v.rv = rv; v.rdata = rd;
      v.e_ctrl = e_c; v.e_bus = e_b; v.e_addr = e_a; v.e_wdata = e_wd;
      v.e_we = e_we; v.e_re = e_re; v.e_busy = e_busy;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      reset = 1'b0; ack = 1'b0; ctrl_in = '0; bus_in = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      //   rst ack ctrl   bus           rdy rv rdata     | e_ctrl e_bus  e_addr  e_wdata       we re busy
      // reset and idle
      add(0, 0, 'h00, 'h0,          0, 0, 'h0,   'h01, 'h0,  'h0,    'h0,          0, 0, 0);
      add(1, 0, 'h00, 'h0,          0, 0, 'h0,   'h01, 'h0,  'h0,    'h0,          0, 0, 0);
      // single write at 0x0010
      add(1, 1, 'h03, 'h10,         0, 0, 'h0,   'h01, 'h0,  'h0,    'h0,          0, 0, 0);
      add(1, 1, 'h03, 'hDEADBEEF,   1, 0, 'h0,   'h02, 'h0,  'h10,   'hDEADBEEF,   1, 0, 1);
      add(1, 1, 'h03, 'h0,          1, 0, 'h0,   'h03, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h03, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h03, 'h0,  'h0,    'h0,          0, 0, 0);
      // burst-4 write at 0x0020, stall on the 2nd data cycle
      add(1, 1, 'h0F, 'h20,         1, 0, 'h0,   'h03, 'h0,  'h0,    'h0,          0, 0, 0);
      add(1, 1, 'h0F, 'h11110000,   1, 0, 'h0,   'h0E, 'h0,  'h20,   'h11110000,   1, 0, 1);
      add(1, 1, 'h0F, 'h22220000,   0, 0, 'h0,   'h0F, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h0F, 'h33330001,   1, 0, 'h0,   'h0E, 'h0,  'h21,   'h33330001,   1, 0, 1);
      add(1, 1, 'h0F, 'h44440002,   1, 0, 'h0,   'h0E, 'h0,  'h22,   'h44440002,   1, 0, 1);
      add(1, 1, 'h0F, 'h55550003,   1, 0, 'h0,   'h0E, 'h0,  'h23,   'h55550003,   1, 0, 1);
      add(1, 1, 'h0F, 'h0,          1, 0, 'h0,   'h0F, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h0F, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h0F, 'h0,  'h0,    'h0,          0, 0, 0);
      // burst-2 read at 0x0040, memory latency 3, second issue stalled one cycle
      add(1, 1, 'h05, 'h40,         1, 0, 'h0,   'h0F, 'h0,  'h0,    'h0,          0, 0, 0);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'h0,  'h40,   'h0,          0, 1, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 1, 'hA0,  'h05, 'h0,  'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h04, 'hA0, 'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          0, 0, 'h0,   'h05, 'hA0, 'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'hA0, 'h41,   'h0,          0, 1, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'hA0, 'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'hA0, 'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 1, 'hA1,  'h05, 'hA0, 'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h04, 'hA1, 'h0,    'h0,          0, 0, 1);
      add(1, 1, 'h05, 'h0,          1, 0, 'h0,   'h05, 'hA1, 'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h05, 'hA1, 'h0,    'h0,          0, 0, 1);
      // stray rvalid while idle must not disturb bus_out
      add(1, 0, 'h00, 'h0,          1, 1, 'hBAD, 'h05, 'hA1, 'h0,    'h0,          0, 0, 0);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h05, 'hA1, 'h0,    'h0,          0, 0, 0);
      // burst-2 write wrapping 0xFFFF -> 0x0000
      add(1, 1, 'h07, 'hFFFF,       1, 0, 'h0,   'h05, 'hA1, 'h0,    'h0,          0, 0, 0);
      add(1, 1, 'h07, 'hCAFE0000,   1, 0, 'h0,   'h06, 'hA1, 'hFFFF, 'hCAFE0000,   1, 0, 1);
      add(1, 1, 'h07, 'hCAFE0001,   1, 0, 'h0,   'h06, 'hA1, 'h0000, 'hCAFE0001,   1, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h07, 'hA1, 'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h00, 'h0,          1, 0, 'h0,   'h07, 'hA1, 'h0,    'h0,          0, 0, 0);
      // burst-4 write aborted after the first word
      add(1, 1, 'h0F, 'h100,        1, 0, 'h0,   'h07, 'hA1, 'h0,    'h0,          0, 0, 0);
      add(1, 1, 'h0F, 'h77770000,   1, 0, 'h0,   'h0E, 'hA1, 'h100,  'h77770000,   1, 0, 1);
      add(1, 0, 'h0F, 'h77770001,   1, 0, 'h0,   'h0E, 'hA1, 'h0,    'h0,          0, 0, 1);
      add(1, 0, 'h0F, 'h77770002,   1, 0, 'h0,   'h0F, 'hA1, 'h0,    'h0,          0, 0, 0);
      add(1, 0, 'h0F, 'h77770003,   1, 0, 'h0,   'h0F, 'hA1, 'h0,    'h0,          0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         reset      = vq[i].rst_n;
         ack        = vq[i].ack;
         ctrl_in    = vq[i].ctrl;
         bus_in     = vq[i].bus;
         mem_ready  = vq[i].rdy;
         mem_rvalid = vq[i].rv;
         mem_rdata  = vq[i].rdata;
         #1;
         check("ctrl_out", i, 32'(ctrl_out), 32'(vq[i].e_ctrl));
         check("bus_out",  i, bus_out, vq[i].e_bus);
         check("mem_we",   i, 32'(mem_we), 32'(vq[i].e_we));
         check("mem_re",   i, 32'(mem_re), 32'(vq[i].e_re));
         check("busy",     i, 32'(busy), 32'(vq[i].e_busy));
         if (vq[i].e_we || vq[i].e_re || !vq[i].rst_n)
            check("mem_addr", i, 32'(mem_addr), 32'(vq[i].e_addr));
         if (vq[i].e_we || !vq[i].rst_n)
            check("mem_wdata", i, mem_wdata, vq[i].e_wdata);
      end

      // Reset asserted while a single-word read waits for memory; a late rvalid is ignored.
      @(negedge clk);
      ack = 1'b1; ctrl_in = 8'h01; bus_in = 32'h0000_0050; mem_ready = 1'b1; mem_rvalid = 1'b0;
      @(negedge clk);
      bus_in = '0;
      #1;
      check("rr_issue_re",   1000, 32'(mem_re), 32'd1);
      check("rr_issue_addr", 1000, 32'(mem_addr), 32'h50);
      @(negedge clk);
      #1;
      check("rr_wait_busy",  1001, 32'(busy), 32'd1);
      check("rr_wait_ctrl",  1001, 32'(ctrl_out), 32'h01);
      check("rr_wait_re",    1001, 32'(mem_re), 32'd0);
      #1;
      reset = 1'b0; ack = 1'b0;
      #1;
      check("rst_ctrl_out",  1002, 32'(ctrl_out), 32'h01);
      check("rst_bus_out",   1002, bus_out, 32'h0);
      check("rst_mem_addr",  1002, 32'(mem_addr), 32'h0);
      check("rst_mem_wdata", 1002, mem_wdata, 32'h0);
      check("rst_mem_we",    1002, 32'(mem_we), 32'd0);
      check("rst_mem_re",    1002, 32'(mem_re), 32'd0);
      check("rst_busy",      1002, 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check("late_rv_bus_out", 1003, bus_out, 32'h0);
      check("late_rv_busy",    1003, 32'(busy), 32'd0);
      check("late_rv_ctrl",    1003, 32'(ctrl_out), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
